// File: rtl/mvau_chk_pkg.sv
// Shared definitions for the MVAU output-stream checker.
//   - geometry helpers: beat count, lane-counter width, beat-address width, lane-index width
//   - default-geometry lane/beat types (PE=4, TDstI=16)
//   - checker FSM state encoding
//   - backpressure LFSR taps (x^16 + x^14 + x^13 + x^11 + 1)
package mvau_chk_pkg;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int unsigned DEF_PE    = 4;
   localparam int unsigned DEF_TDSTI = 16;

   typedef logic [DEF_TDSTI-1:0] lane_t;
   typedef lane_t [DEF_PE-1:0]   beat_t;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_t;

   function automatic int calc_beats(int mmv, int act_w, int matrix_h, int pe);
      return mmv * act_w * matrix_h / pe;
   endfunction

   function automatic int calc_cw(int beats, int pe);
      return $clog2(beats * pe + 1);
   endfunction

   // One address bit minimum so a single-beat run still has a legal port.
   function automatic int calc_aw(int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

   function automatic int calc_lw(int pe);
      return (pe > 1) ? $clog2(pe) : 1;
   endfunction

endpackage

// File: rtl/mvau_chk_lfsr.sv
// 16-bit Fibonacci LFSR used to pace checker backpressure.
//   aclk, aresetn : clock, async active-low reset (state returns to SEED)
//   en            : advance one step this cycle
//   q             : low OUT_W bits of the LFSR state
module mvau_chk_lfsr
   import mvau_chk_pkg::*;
#(
   parameter logic [15:0] SEED  = 16'hACE1,
   parameter int          OUT_W = 4
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             en,
   output logic [OUT_W-1:0] q
);

   logic [15:0] lfsr_q, lfsr_d;
   logic        fb;

   always_comb begin
      fb     = ^(lfsr_q & LFSR_TAPS);
      lfsr_d = en ? {lfsr_q[14:0], fb} : lfsr_q;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) lfsr_q <= SEED;
      else          lfsr_q <= lfsr_d;
   end

   assign q = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/mvau_stream_checker.sv
// AXI-Stream sink and scoreboard for the MVAU output stream.
// Accepts PE-packed beats under LFSR-paced backpressure, reads the golden
// beat through a 1-cycle-latency port and compares all lanes in parallel.
// Optional first-error capture is enabled with macro CHK_FIRST_ERR_EN.
//   start            : 1-cycle pulse, begins a run from IDLE or DONE
//   s0_axis_*        : stream input (lane k at tdata[k*TDstI +: TDstI])
//   gold_en/addr     : golden read request, gold_data valid next cycle
//   busy/done/pass   : run status; timeout when the stream stalls too long
//   match_cnt/mismatch_cnt : lane counts; latency : start-to-final-compare cycles
//   err_* (optional) : first mismatching beat index, lowest bad lane, got/expected
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting beats, comparing one cycle behind
// DRAIN | last beat accepted or timed out, final compare completes
// DONE  | results valid and held until next start
module mvau_stream_checker
   import mvau_chk_pkg::*;
#(
   parameter int          PE         = 4,
   parameter int          TDstI      = 16,
   parameter int          MMV        = 1,
   parameter int          MatrixH    = 8,
   parameter int          ACT_W      = 4,
   parameter int          BP_DENSITY = 16,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int          TIMEOUT    = 4096,
   localparam int         BEATS      = calc_beats(MMV, ACT_W, MatrixH, PE),
   localparam int         CW         = calc_cw(BEATS, PE),
   localparam int         AW         = calc_aw(BEATS)
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  start,
   input  logic                  s0_axis_tvalid,
   input  logic [PE*TDstI-1:0]   s0_axis_tdata,
   output logic                  s0_axis_tready,
   output logic                  gold_en,
   output logic [AW-1:0]         gold_addr,
   input  logic [PE*TDstI-1:0]   gold_data,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic [CW-1:0]         match_cnt,
   output logic [CW-1:0]         mismatch_cnt,
   output logic [31:0]           latency
`ifdef CHK_FIRST_ERR_EN
   ,
   output logic                  err_v,
   output logic [AW-1:0]         err_addr,
   output logic [calc_lw(PE)-1:0] err_lane,
   output logic [TDstI-1:0]      err_got,
   output logic [TDstI-1:0]      err_exp
`endif
);

   localparam int IW = $clog2(TIMEOUT + 1);

   chk_state_t          state_q, state_d;
   logic [AW-1:0]       beat_idx_q, beat_idx_d;
   logic [PE*TDstI-1:0] beat_q, beat_d;
   logic                cmp_v_q, cmp_v_d;
   logic [CW-1:0]       match_q, match_d, mism_q, mism_d;
   logic [31:0]         lat_q, lat_d;
   logic [IW-1:0]       idle_q, idle_d;
   logic                to_q, to_d;
   logic                armed_q;

   logic [3:0]          lfsr_nib;
   logic                tready, accept, run_start;
   logic [PE-1:0]       lane_eq;
   logic [CW-1:0]       eq_cnt;

   mvau_chk_lfsr #(.SEED(LFSR_SEED), .OUT_W(4)) u_lfsr (
      .aclk    (aclk),
      .aresetn (aresetn),
      .en      (state_q == RUN),
      .q       (lfsr_nib)
   );

   // Ready never looks at tvalid; density 16 bypasses the LFSR entirely.
   assign tready    = (state_q == RUN) &&
                      ((BP_DENSITY >= 16) || ({1'b0, lfsr_nib} < 5'(BP_DENSITY)));
   assign accept    = tready && s0_axis_tvalid;
   // armed_q drops a start that lands on the first edge after reset release.
   assign run_start = start && armed_q && ((state_q == IDLE) || (state_q == DONE));

   always_comb begin
      eq_cnt = '0;
      for (int k = 0; k < PE; k++) begin
         lane_eq[k] = (beat_q[k*TDstI +: TDstI] == gold_data[k*TDstI +: TDstI]);
         eq_cnt     = eq_cnt + CW'(lane_eq[k]);
      end
   end

   always_comb begin
      state_d    = state_q;
      beat_idx_d = beat_idx_q;
      beat_d     = accept ? s0_axis_tdata : beat_q;
      cmp_v_d    = accept;
      match_d    = match_q;
      mism_d     = mism_q;
      lat_d      = lat_q;
      idle_d     = idle_q;
      to_d       = to_q;

      if (cmp_v_q) begin
         match_d = match_q + eq_cnt;
         mism_d  = mism_q + (CW'(PE) - eq_cnt);
      end

      if ((state_q == RUN || state_q == DRAIN) && lat_q != 32'hFFFF_FFFF)
         lat_d = lat_q + 32'd1;

      case (state_q)
         IDLE, DONE: begin
            if (run_start) begin
               state_d    = RUN;
               beat_idx_d = '0;
               match_d    = '0;
               mism_d     = '0;
               lat_d      = '0;
               idle_d     = '0;
               to_d       = 1'b0;
            end
         end
         RUN: begin
            if (accept) begin
               idle_d     = '0;
               beat_idx_d = beat_idx_q + AW'(1);
               if (beat_idx_q == AW'(BEATS - 1)) state_d = DRAIN;
            end else if (idle_q == IW'(TIMEOUT - 1)) begin
               to_d    = 1'b1;
               state_d = DRAIN;
            end else begin
               idle_d = idle_q + IW'(1);
            end
         end
         DRAIN: state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         beat_idx_q <= '0;
         beat_q     <= '0;
         cmp_v_q    <= 1'b0;
         match_q    <= '0;
         mism_q     <= '0;
         lat_q      <= '0;
         idle_q     <= '0;
         to_q       <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_idx_q <= beat_idx_d;
         beat_q     <= beat_d;
         cmp_v_q    <= cmp_v_d;
         match_q    <= match_d;
         mism_q     <= mism_d;
         lat_q      <= lat_d;
         idle_q     <= idle_d;
         to_q       <= to_d;
         armed_q    <= 1'b1;
      end
   end

   assign s0_axis_tready = tready;
   assign gold_en        = accept;
   assign gold_addr      = beat_idx_q;
   assign busy           = (state_q == RUN) || (state_q == DRAIN);
   assign done           = (state_q == DONE);
   assign timeout        = to_q;
   assign match_cnt      = match_q;
   assign mismatch_cnt   = mism_q;
   assign latency        = lat_q;
   assign pass           = done && !to_q && (mism_q == '0) && (match_q == CW'(BEATS * PE));

`ifdef CHK_FIRST_ERR_EN
   localparam int LW = calc_lw(PE);

   logic [AW-1:0]    cmp_addr_q, cmp_addr_d;
   logic             err_v_q, err_v_d;
   logic [AW-1:0]    err_addr_q, err_addr_d;
   logic [LW-1:0]    err_lane_q, err_lane_d;
   logic [TDstI-1:0] err_got_q, err_got_d, err_exp_q, err_exp_d;
   logic [LW-1:0]    bad_lane;

   always_comb begin
      // Descending scan so the lowest mismatching lane wins.
      bad_lane = '0;
      for (int k = PE - 1; k >= 0; k--)
         if (!lane_eq[k]) bad_lane = LW'(k);

      cmp_addr_d = accept ? beat_idx_q : cmp_addr_q;
      err_v_d    = err_v_q;
      err_addr_d = err_addr_q;
      err_lane_d = err_lane_q;
      err_got_d  = err_got_q;
      err_exp_d  = err_exp_q;
      if (run_start) begin
         err_v_d = 1'b0;
      end else if (cmp_v_q && !err_v_q && (lane_eq != {PE{1'b1}})) begin
         err_v_d    = 1'b1;
         err_addr_d = cmp_addr_q;
         err_lane_d = bad_lane;
         err_got_d  = beat_q[bad_lane*TDstI +: TDstI];
         err_exp_d  = gold_data[bad_lane*TDstI +: TDstI];
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cmp_addr_q <= '0;
         err_v_q    <= 1'b0;
         err_addr_q <= '0;
         err_lane_q <= '0;
         err_got_q  <= '0;
         err_exp_q  <= '0;
      end else begin
         cmp_addr_q <= cmp_addr_d;
         err_v_q    <= err_v_d;
         err_addr_q <= err_addr_d;
         err_lane_q <= err_lane_d;
         err_got_q  <= err_got_d;
         err_exp_q  <= err_exp_d;
      end
   end

   assign err_v    = err_v_q;
   assign err_addr = err_addr_q;
   assign err_lane = err_lane_q;
   assign err_got  = err_got_q;
   assign err_exp  = err_exp_q;
`endif

endmodule

// File: tb/tb_mvau_stream_checker.sv
module tb_mvau_stream_checker;

   logic aclk, aresetn;
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // dut0: BEATS=8, always ready, TIMEOUT=64
   logic        start0, tvalid0, tready0, gold_en0, busy0, done0, pass0, to0;
   logic [63:0] tdata0, gdata0;
   logic [2:0]  gaddr0;
   logic [5:0]  match0, mism0;
   logic [31:0] lat0;
   // dut1: BEATS=1000, BP_DENSITY=8
   logic        start1, tvalid1, tready1, gold_en1, busy1, done1, pass1, to1;
   logic [63:0] tdata1, gdata1;
   logic [9:0]  gaddr1;
   logic [11:0] match1, mism1;
   logic [31:0] lat1;
`ifdef CHK_FIRST_ERR_EN
   logic        errv0, errv1;
   logic [2:0]  erra0;
   logic [9:0]  erra1;
   logic [1:0]  errl0, errl1;
   logic [15:0] errg0, erre0, errg1, erre1;
`endif

   mvau_stream_checker #(.TIMEOUT(64)) dut0 (
      .aclk(aclk), .aresetn(aresetn), .start(start0),
      .s0_axis_tvalid(tvalid0), .s0_axis_tdata(tdata0), .s0_axis_tready(tready0),
      .gold_en(gold_en0), .gold_addr(gaddr0), .gold_data(gdata0),
      .busy(busy0), .done(done0), .pass(pass0), .timeout(to0),
      .match_cnt(match0), .mismatch_cnt(mism0), .latency(lat0)
`ifdef CHK_FIRST_ERR_EN
      , .err_v(errv0), .err_addr(erra0), .err_lane(errl0), .err_got(errg0), .err_exp(erre0)
`endif
   );

   mvau_stream_checker #(.MMV(125), .BP_DENSITY(8)) dut1 (
      .aclk(aclk), .aresetn(aresetn), .start(start1),
      .s0_axis_tvalid(tvalid1), .s0_axis_tdata(tdata1), .s0_axis_tready(tready1),
      .gold_en(gold_en1), .gold_addr(gaddr1), .gold_data(gdata1),
      .busy(busy1), .done(done1), .pass(pass1), .timeout(to1),
      .match_cnt(match1), .mismatch_cnt(mism1), .latency(lat1)
`ifdef CHK_FIRST_ERR_EN
      , .err_v(errv1), .err_addr(erra1), .err_lane(errl1), .err_got(errg1), .err_exp(erre1)
`endif
   );

   // Lane value chosen so beat 5 lane 2 is 16'h1234.
   function automatic logic [15:0] lane_val(int b, int k);
      return 16'h1234 + 16'(b * 256) + 16'(k * 16) - 16'h0520;
   endfunction

   function automatic logic [63:0] beat_val(int b);
      logic [63:0] r;
      for (int k = 0; k < 4; k++) r[k*16 +: 16] = lane_val(b, k);
      return r;
   endfunction

   int cor_beat = -1, cor_lane = 0, stall0 = 0;

   function automatic logic [63:0] gold_val0(int b);
      logic [63:0] r;
      r = beat_val(b);
      if (b == cor_beat) r[cor_lane*16 +: 16] = 16'h0000;
      return r;
   endfunction

   // Source models: next beat index advances on each accepted handshake.
   int bcnt0 = 0, bcnt1 = 0;
   always @(posedge aclk) begin
      if (start0 && !busy0)          bcnt0 <= 0;
      else if (tvalid0 && tready0)   bcnt0 <= bcnt0 + 1;
      if (start1 && !busy1)          bcnt1 <= 0;
      else if (tvalid1 && tready1)   bcnt1 <= bcnt1 + 1;
      if (gold_en0) gdata0 <= gold_val0(int'(gaddr0));
      if (gold_en1) gdata1 <= beat_val(int'(gaddr1));
   end
   assign tvalid0 = (bcnt0 < stall0);
   assign tdata0  = beat_val(bcnt0);
   assign tvalid1 = (bcnt1 < 1000);
   assign tdata1  = beat_val(bcnt1);

   int n_total = 0, n_pass = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      else             n_pass++;
   endtask

   task automatic pulse_start0();
      @(negedge aclk) start0 = 1'b1;
      @(negedge aclk) start0 = 1'b0;
   endtask

   task automatic wait_done0(input int budget);
      for (int n = 0; n < budget && !done0; n++) @(negedge aclk);
      chk("done_wait", done0, 1'b1);
   endtask

   typedef struct {
      int          stall;
      int          cbeat;
      int          clane;
      int          e_match;
      int          e_mism;
      bit          e_pass;
      bit          e_to;
      int          e_lat;
      bit          e_errv;
      int          e_eaddr;
      int          e_elane;
      logic [15:0] e_got;
      logic [15:0] e_exp;
   } vec_t;

   vec_t vecs[5];
   vec_t v;
   int   busy_n, rdy_n;

   initial begin
      vecs[0] = '{8, -1, 0, 32, 0, 1'b1, 1'b0,  9, 1'b0, 0, 0, 16'h0000, 16'h0000};
      vecs[1] = '{8,  5, 2, 31, 1, 1'b0, 1'b0,  9, 1'b1, 5, 2, 16'h1234, 16'h0000};
      vecs[2] = '{8,  7, 3, 31, 1, 1'b0, 1'b0,  9, 1'b1, 7, 3, 16'h1444, 16'h0000};
      vecs[3] = '{3, -1, 0, 12, 0, 1'b0, 1'b1, 68, 1'b0, 0, 0, 16'h0000, 16'h0000};
      vecs[4] = '{0, -1, 0,  0, 0, 1'b0, 1'b1, 65, 1'b0, 0, 0, 16'h0000, 16'h0000};

      aresetn = 1'b0;
      start0  = 1'b0;
      start1  = 1'b0;
      repeat (3) @(negedge aclk);
      chk("rst_outs0", {tready0, gold_en0, busy0, done0, pass0, to0, match0, mism0, lat0}, '0);
      chk("rst_outs1", {tready1, gold_en1, busy1, done1, pass1, to1, match1, mism1, lat1}, '0);

      // start held across reset release must be dropped
      start0  = 1'b1;
      aresetn = 1'b1;
      @(negedge aclk) start0 = 1'b0;
      chk("start_at_rst_rel", {busy0, done0}, 2'b00);
      @(negedge aclk);

      foreach (vecs[i]) begin
         v        = vecs[i];
         cor_beat = v.cbeat;
         cor_lane = v.clane;
         stall0   = v.stall;
         pulse_start0();
         chk("start_clears", {busy0, done0, to0, match0, mism0}, {1'b1, 14'h0});
`ifdef CHK_FIRST_ERR_EN
         chk("err_v_cleared", errv0, 1'b0);
`endif
         wait_done0(300);
         chk("match_cnt", match0, v.e_match);
         chk("mismatch_cnt", mism0, v.e_mism);
         chk("pass", pass0, v.e_pass);
         chk("timeout", to0, v.e_to);
         chk("latency", lat0, v.e_lat);
`ifdef CHK_FIRST_ERR_EN
         chk("err_v", errv0, v.e_errv);
         if (v.e_errv) begin
            chk("err_addr", erra0, v.e_eaddr);
            chk("err_lane", errl0, v.e_elane);
            chk("err_got", errg0, v.e_got);
            chk("err_exp", erre0, v.e_exp);
         end
`endif
      end

      // start pulsed during RUN is ignored
      cor_beat = -1;
      stall0   = 8;
      pulse_start0();
      @(negedge aclk) start0 = 1'b1;
      @(negedge aclk) start0 = 1'b0;
      wait_done0(100);
      chk("run_start_match", match0, 32);
      chk("run_start_lat", lat0, 9);
      chk("run_start_pass", pass0, 1'b1);

      // reset in the middle of a run
      pulse_start0();
      for (int n = 0; n < 50 && bcnt0 < 4; n++) @(negedge aclk);
      chk("reach_beat4", bcnt0, 4);
      aresetn = 1'b0;
      #1;
      chk("midrun_rst", {tready0, gold_en0, busy0, done0, pass0, to0, match0, mism0, lat0}, '0);
      @(negedge aclk) aresetn = 1'b1;
      repeat (2) @(negedge aclk);
      pulse_start0();
      wait_done0(100);
      chk("after_rst_match", match0, 32);
      chk("after_rst_pass", pass0, 1'b1);

      // long run under ~50% backpressure
      busy_n = 0;
      rdy_n  = 0;
      @(negedge aclk) start1 = 1'b1;
      @(negedge aclk) start1 = 1'b0;
      for (int n = 0; n < 10000 && !done1; n++) begin
         if (busy1)   busy_n++;
         if (tready1) rdy_n++;
         @(negedge aclk);
      end
      chk("bp_done", done1, 1'b1);
      chk("bp_beats", bcnt1, 1000);
      chk("bp_match", match1, 4000);
      chk("bp_mismatch", mism1, 0);
      chk("bp_pass", pass1, 1'b1);
      chk("bp_latency", lat1, busy_n);
      chk("bp_duty_40_60", (rdy_n * 10 >= busy_n * 4) && (rdy_n * 10 <= busy_n * 6), 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mvau_stream_checker.md
Name: mvau_stream_checker

Overview:
- Synthesizable AXI-Stream sink and scoreboard for the MVAU output stream (m0_axis of mvau_top).
- Consumes PE-packed output beats under configurable pseudo-random backpressure and compares every lane against a golden-output memory through a 1-cycle-latency read port.
- Reports match/mismatch counts, latency in cycles, timeout and pass/fail.
- Replaces bench-only comparison loops; usable both in simulation and in on-FPGA self-test.

Parameters:
- PE, 4, output lanes per beat
- TDstI, 16, lane word length
- MMV, 1, multi-vector count
- MatrixH, 8, output channels; must be a multiple of PE
- ACT_W, 4, output pixels per vector (OFMDim*OFMDim)
- BP_DENSITY, 16, ready density in 1/16ths; 16 = always ready; legal range 1..16
- LFSR_SEED, 16'hACE1, backpressure LFSR seed; must be non-zero
- TIMEOUT, 4096, idle cycles in RUN before abort
- Derived: BEATS = MMV*ACT_W*MatrixH/PE; CW = $clog2(BEATS*PE+1); AW = $clog2(BEATS)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a check run
- s0_axis_tvalid  in  1  DUT output valid
- s0_axis_tdata  in  PE*TDstI  lane k at bits [k*TDstI +: TDstI]
- s0_axis_tready  out  1  checker ready
- gold_en  out  1  golden read enable
- gold_addr  out  AW  golden beat index
- gold_data  in  PE*TDstI  golden beat, same lane packing, valid 1 cycle after gold_en
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- pass  out  1  done & no mismatch & no timeout & match_cnt==BEATS*PE
- timeout  out  1  run aborted by TIMEOUT
- match_cnt  out  CW  matching lanes
- mismatch_cnt  out  CW  mismatching lanes
- latency  out  32  cycles from start to final compare; saturating

Behaviour:
- Reset: all outputs 0, state IDLE, LFSR=LFSR_SEED, counters cleared. Reset mid-run aborts immediately with the same values.
- Beat order: m outermost, then pixel i, then neuron fold j. gold_addr = beat_idx = (m*ACT_W+i)*(MatrixH/PE)+j.
- FSM states:
  - IDLE: start -> RUN; clears counters, done, pass, timeout; latency=0.
  - RUN: tready = (BP_DENSITY==16) | (lfsr[3:0] < BP_DENSITY). The LFSR (x^16+x^14+x^13+x^11) advances every RUN cycle. accept = tvalid & tready.
    - On accept: gold_en=1, gold_addr=beat_idx, tdata registered, cmp_v set next cycle, beat_idx++.
    - Accept of beat BEATS-1 -> DRAIN.
  - DRAIN: tready=0; waits for the final compare -> DONE.
  - DONE: done=1 and pass valid; start -> RUN (new run). Other inputs ignored.
- tready depends only on state and LFSR, never on tvalid. tdata is sampled only on accept.
- Compare stage: registered beat vs gold_data, 1 cycle after accept; all PE lanes compared in parallel.
  - match_cnt += popcount(equal lanes); mismatch_cnt += PE - popcount.
  - Back-to-back accepts are fully pipelined: one compare per cycle, no stall.
- latency increments every cycle in RUN/DRAIN and saturates at 32'hFFFFFFFF.
- Timeout: idle counter counts RUN cycles without accept and resets on accept. Reaching TIMEOUT -> DONE with timeout=1, pass=0; any in-flight compare completes first.
- start while RUN/DRAIN: ignored. start coincident with reset release: ignored.
- busy = RUN | DRAIN.

Optional Feature:
- Macro: CHK_FIRST_ERR_EN.
- When defined, adds outputs err_v (1), err_addr (AW), err_lane ($clog2(PE), min 1), err_got (TDstI) and err_exp (TDstI).
  - They latch the first mismatching beat, taking the lowest mismatching lane within it.
  - Held until the next start; err_v=0 after reset/start.
- When undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package mvau_chk_pkg:
  - localparam functions for BEATS, CW and AW
  - typedef lane_t (logic [TDstI-1:0]) and beat_t (lane_t [PE-1:0])
  - enum chk_state_t {IDLE, RUN, DRAIN, DONE}
  - LFSR taps constant
- One sub-module: mvau_chk_lfsr, a 16-bit Fibonacci LFSR with enable and seed parameter.

Test Plan:
- Defaults (BEATS=8), BP_DENSITY=16, tvalid held 1, gold==data -> tready 1 throughout; done after cycle 9; match_cnt=32, mismatch_cnt=0, pass=1, latency=9.
- Same, with gold beat 5 lane 2 = 16'h0000 vs data 16'h1234 -> mismatch_cnt=1, match_cnt=31, pass=0; with CHK_FIRST_ERR_EN: err_addr=5, err_lane=2, err_got=16'h1234, err_exp=16'h0000.
- BP_DENSITY=8, tvalid 1 -> tready duty ~50% over 1000 beats (MMV=125), no beat dropped or duplicated; match_cnt=4000, pass=1.
- tvalid stuck 0 after 3 beats, TIMEOUT=64 -> done, timeout=1, pass=0, match_cnt=12, latency=3+64(+1 compare).
- aresetn low at beat 4 then new start -> all counters 0 after reset; second run from beat 0 passes with match_cnt=32.
- start pulsed in RUN -> ignored; counts unaffected; start in DONE -> counters cleared, new run passes.
